sdram_page_arbiter: RTL and testbench
=====================================

SDRAM_PAGE_ARBITER -- requirements
Module: sdram_page_arbiter

Interface
REQ-001 Parameter: PAGES, 32768, page-ring depth; power of two; max 32768, covering the 15-bit bank+row space.
REQ-002 Parameter: REF_INTERVAL, 374, clk cycles per refresh tick (7.8 us at 48 MHz).
REQ-003 Parameter: REF_MAX, 8, saturation limit of pending refreshes.
REQ-004 clk  in  1  system clock, 48 MHz, all logic on rising edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 wr_req  in  1  level; upstream FIFO holds one full page (512 words).
REQ-007 rd_req  in  1  level; downstream consumer can accept one full page.
REQ-008 op_ready  in  1  SDRAM controller idle, can accept an operation.
REQ-009 op_done  in  1  one-cycle pulse; accepted operation finished.
REQ-010 op_valid  out  1  operation offered to the controller.
REQ-011 op_cmd  out  2  0 = none, 1 = page write, 2 = page read, 3 = auto-refresh.
REQ-012 op_page  out  15  page address {BA[1:0], row[12:0]}; 0 for refresh.
REQ-013 pages_used  out  16  pages written but not yet read.
REQ-014 full / empty  out  1 each  pages_used == PAGES / pages_used == 0.
REQ-015 ref_overrun  out  1  sticky; a refresh tick arrived while pending == REF_MAX.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-017 IDLE: evaluates candidates each cycle; moves to ISSUE on the next edge when any candidate exists.
REQ-018 Refresh candidate: ref_pending > 0.
REQ-019 Write candidate: wr_req & !full.
REQ-020 Read candidate: rd_req & !empty.
REQ-021 Priority: refresh over write/read; write vs read alternates by round-robin on last_was_write, with write winning the first tie after reset.
REQ-022 op_cmd and op_page latch on IDLE->ISSUE and hold stable in ISSUE; op_page = wr_ptr for write, rd_ptr for read.
REQ-023 ISSUE: op_valid = 1; an edge with op_ready = 1 completes the handshake and moves to WAIT_DONE with op_valid = 0.
REQ-024 ISSUE: no re-arbitration, even if wr_req/rd_req deassert.
REQ-025 WAIT_DONE: op_done moves the FSM to IDLE and applies that operation's update on the same edge.
REQ-026 On op_done, write: wr_ptr+1, pages_used+1, last_was_write = 1.
REQ-027 On op_done, read: rd_ptr+1, pages_used-1, last_was_write = 0.
REQ-028 On op_done, refresh: ref_pending-1.
REQ-029 op_done outside WAIT_DONE is ignored.
REQ-030 Pointers wrap PAGES-1 -> 0; full and empty derive from pages_used only.
REQ-031 Refresh timer: counts 0..REF_INTERVAL-1 continuously from reset release; the tick at the terminal value increments ref_pending, saturating at REF_MAX.
REQ-032 Tick at ref_pending == REF_MAX sets ref_overrun.
REQ-033 Tick and refresh op_done on the same edge leave ref_pending unchanged.
REQ-034 Minimum decision latency: IDLE to op_valid = 1 cycle; op_done to next op_valid = 2 cycles.

Reset
REQ-035 n_rst low immediately forces FSM = IDLE, op_valid = 0, op_cmd = 0, op_page = 0.
REQ-036 n_rst low also clears wr_ptr, rd_ptr, pages_used, ref_pending, refresh timer, last_was_write, ref_overrun; empty = 1, full = 0.
REQ-037 Reset during ISSUE or WAIT_DONE abandons the operation; a later op_done is ignored (REQ-029).

Structure
REQ-038 Shared package holds: op_cmd encodings, FSM state encodings, REF_INTERVAL/REF_MAX defaults.
REQ-039 Refresh timer and pending counter form one sub-module, sdram_refresh_scheduler (outputs ref_pending, ref_overrun; input ref_done).

Verification
REQ-040 After reset, wr_req = 1, op_ready = 1, op_done 3 cycles after accept -> op_cmd = 1, op_page = 0, then op_page = 1; pages_used = 2 after two ops.
REQ-041 wr_req = rd_req = 1 with 4 pages stored, no refresh due -> op_cmd alternates 1, 2, 1, 2; pages_used stays 4 or 5.
REQ-042 Refresh tick during a write's WAIT_DONE -> next issued op_cmd = 3 even with wr_req = 1; ref_pending returns to 0 after op_done.
REQ-043 op_ready = 0 for 1000 cycles -> op_valid held, op_cmd/op_page stable; ref_pending saturates at 8 and ref_overrun = 1.
REQ-044 PAGES = 4, write 4 pages -> full = 1 and no write issued; read 1 page -> rd_ptr = 1, write issues with op_page = 0 (wrap).
REQ-045 n_rst pulsed in WAIT_DONE, then op_done pulse -> all outputs at reset values; no pointer change.

Source files
------------

// File: rtl/sdram_page_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_page_arbiter_pkg
// Shared definitions for the SDRAM page arbiter and its refresh scheduler:
// operation command encodings, FSM state encodings, refresh defaults, bus
// widths and a counter-width helper.
// -----------------------------------------------------------------------------
package sdram_page_arbiter_pkg;

    // Operation command encodings presented on op_cmd
    localparam logic [1:0] CMD_NONE    = 2'd0;
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_REFRESH = 2'd3;

    // Arbiter FSM state encodings
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // Refresh defaults: 7.8 us at 48 MHz, up to 8 postponed refreshes
    localparam int REF_INTERVAL_DEF = 374;
    localparam int REF_MAX_DEF      = 8;

    // Page address is {BA[1:0], row[12:0]}; page count must reach 32768
    localparam int PAGE_W = 15;
    localparam int USED_W = 16;

    // Bits needed to hold values 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sdram_page_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_page_arbiter_if
// Groups the arbiter's request, SDRAM-operation handshake and status signals.
//   wr_req / rd_req   : upstream page-ready / downstream page-space levels
//   op_ready, op_done : SDRAM controller idle flag and completion pulse
//   op_valid, op_cmd, op_page : offered operation
//   pages_used, full, empty, ref_overrun : status
// Modport master is the arbiter; modport slave is the surrounding system.
// -----------------------------------------------------------------------------
interface sdram_page_arbiter_if;
    import sdram_page_arbiter_pkg::*;

    logic              wr_req;
    logic              rd_req;
    logic              op_ready;
    logic              op_done;
    logic              op_valid;
    logic [1:0]        op_cmd;
    logic [PAGE_W-1:0] op_page;
    logic [USED_W-1:0] pages_used;
    logic              full;
    logic              empty;
    logic              ref_overrun;

    modport master (
        input  wr_req, rd_req, op_ready, op_done,
        output op_valid, op_cmd, op_page, pages_used, full, empty, ref_overrun
    );

    modport slave (
        output wr_req, rd_req, op_ready, op_done,
        input  op_valid, op_cmd, op_page, pages_used, full, empty, ref_overrun
    );

endinterface

// File: rtl/sdram_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_refresh_scheduler
// Free-running refresh interval timer plus a saturating count of refreshes
// that are due but not yet performed.
//   clk, n_rst   : clock, asynchronous active-low reset
//   ref_done     : a refresh operation finished this cycle
//   ref_pending  : refreshes owed (0..REF_MAX)
//   ref_overrun  : sticky, a tick arrived while ref_pending was already full
// -----------------------------------------------------------------------------
module sdram_refresh_scheduler
    import sdram_page_arbiter_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int REF_MAX      = REF_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          ref_done,
    output logic [cnt_width(REF_MAX)-1:0] ref_pending,
    output logic                          ref_overrun
);
    localparam int TMR_W  = cnt_width(REF_INTERVAL - 1);
    localparam int PEND_W = cnt_width(REF_MAX);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REF_INTERVAL - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(REF_MAX);

    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              tick;

    always_comb begin
        tick      = (timer_q == TMR_LAST);
        timer_d   = tick ? '0 : timer_q + 1'b1;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (tick && (pending_q == PEND_MAX)) begin
            overrun_d = 1'b1;
        end

        // A tick and a completed refresh in the same cycle cancel out
        if (tick && !ref_done) begin
            if (pending_q != PEND_MAX) begin
                pending_d = pending_q + 1'b1;
            end
        end else if (ref_done && !tick) begin
            if (pending_q != '0) begin
                pending_d = pending_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_q   <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign ref_pending = pending_q;
    assign ref_overrun = overrun_q;

endmodule

// File: rtl/sdram_page_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_page_arbiter
// Arbitrates whole-page SDRAM writes, reads and auto-refreshes over a ring of
// PAGES pages. One operation is in flight at a time: IDLE picks a candidate,
// ISSUE offers it until the controller takes it, WAIT_DONE waits for op_done
// and then commits the pointer / occupancy update.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : sdram_page_arbiter_if.master (requests, handshake, status)
// -----------------------------------------------------------------------------
module sdram_page_arbiter
    import sdram_page_arbiter_pkg::*;
#(
    parameter int PAGES        = 32768,
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int REF_MAX      = REF_MAX_DEF
) (
    input logic                  clk,
    input logic                  n_rst,
    sdram_page_arbiter_if.master bus
);
    localparam int PTR_W  = cnt_width(PAGES - 1);
    localparam int PEND_W = cnt_width(REF_MAX);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PAGES - 1);
    localparam logic [USED_W-1:0] USED_FULL = USED_W'(PAGES);

    logic [1:0]        state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [USED_W-1:0] used_q, used_d;
    logic              last_wr_q, last_wr_d;

    logic [PEND_W-1:0] ref_pending;
    logic              ref_overrun;
    logic              ref_done;
    logic              full, empty;
    logic              ref_cand, wr_cand, rd_cand;

    // Explicit wrap keeps the ring correct whatever PTR_W works out to
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full     = (used_q == USED_FULL);
    assign empty    = (used_q == '0);
    assign ref_cand = (ref_pending != '0);
    assign wr_cand  = bus.wr_req && !full;
    assign rd_cand  = bus.rd_req && !empty;
    assign ref_done = (state_q == ST_WAIT_DONE) && bus.op_done && (cmd_q == CMD_REFRESH);

    sdram_refresh_scheduler #(
        .REF_INTERVAL (REF_INTERVAL),
        .REF_MAX      (REF_MAX)
    ) u_refresh (
        .clk         (clk),
        .n_rst       (n_rst),
        .ref_done    (ref_done),
        .ref_pending (ref_pending),
        .ref_overrun (ref_overrun)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        page_d    = page_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        used_d    = used_q;
        last_wr_d = last_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (ref_cand) begin
                    cmd_d   = CMD_REFRESH;
                    page_d  = '0;
                    state_d = ST_ISSUE;
                // On a write/read tie, write goes unless the last data op was a write
                end else if (wr_cand && (!rd_cand || !last_wr_q)) begin
                    cmd_d   = CMD_WRITE;
                    page_d  = PAGE_W'(wr_ptr_q);
                    state_d = ST_ISSUE;
                end else if (rd_cand) begin
                    cmd_d   = CMD_READ;
                    page_d  = PAGE_W'(rd_ptr_q);
                    state_d = ST_ISSUE;
                end
            end

            // Operation is committed once offered; request changes are ignored
            ST_ISSUE: begin
                if (bus.op_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (bus.op_done) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NONE;
                    page_d  = '0;
                    if (cmd_q == CMD_WRITE) begin
                        wr_ptr_d  = ptr_inc(wr_ptr_q);
                        used_d    = used_q + 1'b1;
                        last_wr_d = 1'b1;
                    end else if (cmd_q == CMD_READ) begin
                        rd_ptr_d  = ptr_inc(rd_ptr_q);
                        used_d    = used_q - 1'b1;
                        last_wr_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_NONE;
                page_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_NONE;
            page_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            used_q    <= '0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            page_q    <= page_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            used_q    <= used_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign bus.op_valid    = (state_q == ST_ISSUE);
    assign bus.op_cmd      = cmd_q;
    assign bus.op_page     = page_q;
    assign bus.pages_used  = used_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.ref_overrun = ref_overrun;

endmodule

// File: tb/tb_sdram_page_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_page_arbiter
// Drives the arbiter as both the page source/sink and the SDRAM controller,
// and checks every cycle against a behavioural model of the page ring and
// refresh bookkeeping, plus directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_sdram_page_arbiter;
    import sdram_page_arbiter_pkg::*;

    localparam int PAGES   = 8;
    localparam int REF_INT = 64;
    localparam int REF_MX  = 8;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    sdram_page_arbiter_if bus();

    sdram_page_arbiter #(
        .PAGES        (PAGES),
        .REF_INTERVAL (REF_INT),
        .REF_MAX      (REF_MX)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: phase 0 = nothing in flight, 1 = offered, 2 = accepted
    int m_timer, m_pend, m_used, m_wp, m_rp, m_lastw, m_phase, m_cmd, m_page, m_ovr;

    // Controller behaviour knobs
    int rdy_mode = 1;     // 0 never ready, 1 always ready, 2 random
    int done_dly = 2;
    int wait_cnt = 0;
    bit rand_dly = 0;
    bit spur     = 0;
    bit man_done = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_timer = 0; m_pend = 0; m_used = 0; m_wp = 0; m_rp = 0;
        m_lastw = 0; m_phase = 0; m_cmd = 0; m_page = 0; m_ovr = 0;
    endtask

    // One rising edge of the specified behaviour, from inputs held this cycle
    task automatic model_step();
        bit tick;
        bit rdone;
        int c;
        bit w;
        bit r;
        if (!n_rst) begin
            model_reset();
            return;
        end
        tick  = (m_timer == REF_INT - 1);
        rdone = 0;
        case (m_phase)
            0: begin
                c = 0;
                w = bus.wr_req && (m_used < PAGES);
                r = bus.rd_req && (m_used > 0);
                if (m_pend > 0) c = 3;
                else if (w && r) c = m_lastw ? 2 : 1;
                else if (w) c = 1;
                else if (r) c = 2;
                if (c != 0) begin
                    m_phase = 1;
                    m_cmd   = c;
                    m_page  = (c == 1) ? m_wp : (c == 2) ? m_rp : 0;
                end
            end
            1: if (bus.op_ready) m_phase = 2;
            default: if (bus.op_done) begin
                if (m_cmd == 1) begin
                    m_wp = (m_wp + 1) % PAGES; m_used++; m_lastw = 1;
                end else if (m_cmd == 2) begin
                    m_rp = (m_rp + 1) % PAGES; m_used--; m_lastw = 0;
                end else begin
                    rdone = 1;
                end
                m_phase = 0; m_cmd = 0; m_page = 0;
            end
        endcase
        if (tick && m_pend == REF_MX) m_ovr = 1;
        if (tick && !rdone) begin
            if (m_pend < REF_MX) m_pend++;
        end else if (rdone && !tick) begin
            m_pend--;
        end
        m_timer = tick ? 0 : m_timer + 1;
    endtask

    // Advance one clock: model follows the edge, then the controller responds
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        bus.op_done = 1'b0;
        if (m_phase == 2) begin
            if (wait_cnt >= done_dly) begin
                bus.op_done = 1'b1;
                wait_cnt = 0;
                if (rand_dly) done_dly = $urandom_range(0, 4);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (man_done || (spur && m_phase != 2 && $urandom_range(0, 7) == 0)) bus.op_done = 1'b1;
        case (rdy_mode)
            0:       bus.op_ready = 1'b0;
            1:       bus.op_ready = 1'b1;
            default: bus.op_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        model_reset();
        repeat (2) cycle();
        n_rst = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (m_phase != 0 && n < 3000) begin
            cycle();
            n++;
        end
        if (m_phase != 0) chk("drain_timeout", m_phase, 0);
    endtask

    // Wait for the start of a new offer; optionally skip refresh offers
    task automatic wait_offer(input string nm, input bit skip_ref,
                              output int cmd, output int page, output int used);
        int n = 0;
        bit got = 0;
        while (!got && n < 3000) begin
            while (bus.op_valid && n < 3000) begin cycle(); n++; end
            while (!bus.op_valid && n < 3000) begin cycle(); n++; end
            if (bus.op_valid && !(skip_ref && bus.op_cmd == CMD_REFRESH)) got = 1;
        end
        cmd  = bus.op_cmd;
        page = bus.op_page;
        used = bus.pages_used;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: got no offer, expected one within %0d cycles", nm, n);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("op_valid", bus.op_valid, (m_phase == 1));
        if (m_phase == 1) begin
            chk("op_cmd", bus.op_cmd, m_cmd);
            chk("op_page", bus.op_page, m_page);
        end
        chk("pages_used", bus.pages_used, m_used);
        chk("full", bus.full, (m_used == PAGES));
        chk("empty", bus.empty, (m_used == 0));
        chk("ref_overrun", bus.ref_overrun, m_ovr);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, p, u, n, unstable, wr_issued, c0, p0;
        int exp_cmd [4];
        int exp_used[4];
        bus.wr_req   = 1'b0;
        bus.rd_req   = 1'b0;
        bus.op_ready = 1'b1;
        bus.op_done  = 1'b0;
        model_reset();

        // Reset values while n_rst is held low
        n_rst = 1'b0;
        repeat (2) cycle();
        chk("rst_valid", bus.op_valid, 0);
        chk("rst_cmd", bus.op_cmd, 0);
        chk("rst_page", bus.op_page, 0);
        chk("rst_used", bus.pages_used, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_overrun", bus.ref_overrun, 0);
        n_rst = 1'b1;

        // Two back-to-back page writes
        bus.wr_req = 1'b1;
        wait_offer("w1", 0, c, p, u);
        chk("w1_cmd", c, 1);
        chk("w1_page", p, 0);
        wait_offer("w2", 0, c, p, u);
        chk("w2_cmd", c, 1);
        chk("w2_page", p, 1);
        bus.wr_req = 1'b0;
        drain();
        repeat (3) cycle();
        chk("w2_used", bus.pages_used, 2);

        // Refresh tick lands in a write's WAIT_DONE: refresh wins next
        do_reset();
        done_dly = 80;
        bus.wr_req = 1'b1;
        wait_offer("rf_w", 0, c, p, u);
        chk("rf_w_cmd", c, 1);
        wait_offer("rf_r", 0, c, p, u);
        chk("rf_r_cmd", c, 3);
        chk("rf_r_page", p, 0);
        done_dly = 2;
        wait_offer("rf_w2", 0, c, p, u);
        chk("rf_w2_cmd", c, 1);
        chk("rf_w2_page", p, 1);
        chk("rf_w2_used", u, 1);
        bus.wr_req = 1'b0;
        drain();

        // Build 4 stored pages with a read last, then alternate
        n = 0;
        bus.wr_req = 1'b1;
        while (m_used < 5 && n < 3000) begin cycle(); n++; end
        bus.wr_req = 1'b0;
        drain();
        bus.rd_req = 1'b1;
        while (m_used > 4 && n < 6000) begin cycle(); n++; end
        bus.rd_req = 1'b0;
        drain();
        exp_cmd  = '{1, 2, 1, 2};
        exp_used = '{4, 5, 4, 5};
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_offer("rr", 1, c, p, u);
            chk("rr_cmd", c, exp_cmd[i]);
            chk("rr_used", u, exp_used[i]);
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        drain();

        // Fill the ring, confirm no write while full, then wrap
        do_reset();
        n = 0;
        bus.wr_req = 1'b1;
        while (m_used < PAGES && n < 3000) begin cycle(); n++; end
        wr_issued = 0;
        repeat (40) begin
            cycle();
            if (bus.op_valid && bus.op_cmd == CMD_WRITE) wr_issued++;
        end
        chk("full_no_write", wr_issued, 0);
        chk("full_flag", bus.full, 1);
        bus.rd_req = 1'b1;
        wait_offer("wrap_rd", 1, c, p, u);
        chk("wrap_rd_cmd", c, 2);
        chk("wrap_rd_page", p, 0);
        bus.rd_req = 1'b0;
        wait_offer("wrap_wr", 1, c, p, u);
        chk("wrap_wr_cmd", c, 1);
        chk("wrap_wr_page", p, 0);
        bus.wr_req = 1'b0;
        drain();

        // Controller stalls for 1000 cycles
        rdy_mode = 0;
        bus.op_ready = 1'b0;
        bus.rd_req = 1'b1;
        wait_offer("stall", 0, c0, p0, u);
        bus.rd_req = 1'b0;
        unstable = 0;
        repeat (1000) begin
            cycle();
            if (!(bus.op_valid && bus.op_cmd == c0[1:0] && bus.op_page == p0[PAGE_W-1:0])) unstable++;
        end
        chk("stall_stable", unstable, 0);
        chk("stall_overrun", bus.ref_overrun, 1);
        rdy_mode = 1;
        drain();

        // Reset while an operation is outstanding, then a stray op_done
        done_dly = 100000;
        bus.rd_req = 1'b1;
        n = 0;
        while (m_phase != 2 && n < 3000) begin cycle(); n++; end
        n_rst = 1'b0;
        model_reset();
        repeat (2) cycle();
        n_rst = 1'b1;
        bus.rd_req = 1'b0;
        done_dly = 2;
        man_done = 1;
        cycle();
        man_done = 0;
        repeat (2) cycle();
        chk("ab_valid", bus.op_valid, 0);
        chk("ab_cmd", bus.op_cmd, 0);
        chk("ab_page", bus.op_page, 0);
        chk("ab_used", bus.pages_used, 0);
        chk("ab_empty", bus.empty, 1);
        chk("ab_overrun", bus.ref_overrun, 0);
        bus.wr_req = 1'b1;
        wait_offer("ab_wr", 0, c, p, u);
        chk("ab_wr_cmd", c, 1);
        chk("ab_wr_page", p, 0);
        bus.wr_req = 1'b0;
        drain();

        // Randomised traffic, controller timing and occasional resets
        do_reset();
        rand_dly = 1;
        spur     = 1;
        rdy_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.wr_req = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) bus.rd_req = $urandom_range(0, 1);
            if ($urandom_range(0, 399) == 0) begin
                n_rst = 1'b0;
                model_reset();
                cycle();
                n_rst = 1'b1;
            end
            cycle();
        end
        spur     = 0;
        rand_dly = 0;
        done_dly = 2;
        rdy_mode = 1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        drain();
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
